// File: rtl/fft_stream_adapter.sv
`timescale 1ns/1ps
// Purpose : streaming front/back end for the 16-point FFT core (serial in -> parallel core -> serial out).
// Latency : 16th input handshake at T -> fft_start at T+1; endop rising edge sampled at E -> out_valid at E+1.
// Backpressure: in_ready is high only while filling; out_valid holds its beat stable until out_ready.
//
// Ports:
//   clock, reset               single clock, async active-low reset
//   in_valid/in_ready/in_re/in_im     input sample stream
//   out_valid/out_ready/out_re/out_im/out_idx/out_last   output bin stream
//   fft_data_in, fft_start     packed frame and one-cycle start strobe to the core
//   fft_endop, fft_data_out    core done flag (rising edge) and packed result
//   timeout_err                sticky: a frame was abandoned waiting for endop
//   frames_done                count of fully drained frames, wraps
module fft_stream_adapter #(
    parameter int DW      = 16,
    parameter int NPTS    = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_re,
    input  logic [DW-1:0]          in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_re,
    output logic [DW-1:0]          out_im,
    output logic [3:0]             out_idx,
    output logic                   out_last,
    output logic [2*DW*NPTS-1:0]   fft_data_in,
    output logic                   fft_start,
    input  logic                   fft_endop,
    input  logic [2*DW*NPTS-1:0]   fft_data_out,
    output logic                   timeout_err,
    output logic [15:0]            frames_done
);

    localparam int SW = 2 * DW;
    localparam int FW = SW * NPTS;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [3:0] LAST_IDX = 4'(NPTS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [TW-1:0] tcnt;
    logic          endop_q;
    logic [FW-1:0] out_buf;
    logic [SW-1:0] out_slot;

    logic in_hs;
    logic out_hs;
    logic endop_rise;
    logic timed_out;

    assign in_ready   = (state == S_FILL);
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    // History resets to 1 so an endop already high at reset release is not an edge.
    assign endop_rise = fft_endop && !endop_q;
    assign timed_out  = (tcnt == TMO_LAST);

    // Output beat is a pure decode of the captured buffer, so it is stable while stalled.
    assign out_slot = out_buf[out_idx*SW +: SW];
    assign out_re   = out_slot[SW-1:DW];
    assign out_im   = out_slot[DW-1:0];
    assign out_last = out_valid && (out_idx == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_FILL;
            cnt         <= '0;
            tcnt        <= '0;
            endop_q     <= 1'b1;
            fft_data_in <= '0;
            out_buf     <= '0;
            fft_start   <= 1'b0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            timeout_err <= 1'b0;
            frames_done <= '0;
        end else begin
            endop_q   <= fft_endop;
            // Registered strobe: high exactly in the single START cycle.
            fft_start <= 1'b0;

            case (state)
                S_FILL: begin
                    if (in_hs) begin
                        fft_data_in[cnt*SW +: SW] <= {in_re, in_im};
                        if (cnt == LAST_IDX) begin
                            cnt       <= '0;
                            state     <= S_START;
                            fft_start <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end

                S_START: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    // Edge takes priority over a timeout landing in the same cycle.
                    if (endop_rise) begin
                        out_buf   <= fft_data_out;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        state     <= S_DRAIN;
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                        state       <= S_FILL;
                    end
                end

                S_DRAIN: begin
                    if (out_hs) begin
                        if (out_idx == LAST_IDX) begin
                            out_idx     <= '0;
                            out_valid   <= 1'b0;
                            frames_done <= frames_done + 16'd1;
                            state       <= S_FILL;
                        end else begin
                            out_idx <= out_idx + 4'd1;
                        end
                    end
                end

                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stream_adapter.sv
`timescale 1ns/1ps
// Purpose : directed self-checking bench for fft_stream_adapter (TIMEOUT shortened to 64).
// Latency : inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: sink stall pattern 1,0,0 repeating in the backpressure frame.
module tb_fft_stream_adapter;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [15:0]    in_re;
    logic [15:0]    in_im;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    out_re;
    logic [15:0]    out_im;
    logic [3:0]     out_idx;
    logic           out_last;
    logic [511:0]   fft_data_in;
    logic           fft_start;
    logic           fft_endop;
    logic [511:0]   fft_data_out;
    logic           timeout_err;
    logic [15:0]    frames_done;

    int n_checks = 0;
    int n_pass   = 0;

    fft_stream_adapter #(.DW(16), .NPTS(16), .TIMEOUT(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_re        (in_re),
        .in_im        (in_im),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_re       (out_re),
        .out_im       (out_im),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .fft_data_in  (fft_data_in),
        .fft_start    (fft_start),
        .fft_endop    (fft_endop),
        .fft_data_out (fft_data_out),
        .timeout_err  (timeout_err),
        .frames_done  (frames_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Sample k: re = bre + k, im = bim - k.
    task automatic feed(input logic [15:0] bre, input logic [15:0] bim, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_re    = 16'(bre + 16'(k));
            in_im    = 16'(bim - 16'(k));
            check("in_ready_fill", in_ready, 1);
            check("fft_start_quiet", fft_start, 0);
            tick();
        end
        in_valid = 1'b0;
        if (n == 16) begin
            check("fft_start_pulse", fft_start, 1);
            check("in_ready_start", in_ready, 0);
        end
    endtask

    // Core result: slot k = {bre + k, bim + k}.
    task automatic load_core(input logic [15:0] bre, input logic [15:0] bim);
        for (int k = 0; k < 16; k++)
            fft_data_out[k*32 +: 32] = {16'(bre + 16'(k)), 16'(bim + 16'(k))};
    endtask

    // Called in the START cycle; raises endop 'delay' cycles later.
    task automatic respond(input int delay, input logic [15:0] bre, input logic [15:0] bim);
        load_core(bre, bim);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("fft_start_once", fft_start, 0);
            check("wait_no_valid", out_valid, 0);
            check("wait_in_ready", in_ready, 0);
        end
        fft_endop = 1'b1;
        tick();
        check("valid_after_edge", out_valid, 1);
        fft_endop = 1'b0;
    endtask

    task automatic drain(input logic [15:0] bre, input logic [15:0] bim, input bit stall, input int nbeats);
        int idx = 0;
        int cyc = 0;
        while (idx < nbeats && cyc < 200) begin
            out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            check("out_valid", out_valid, 1);
            check("out_idx", out_idx, 64'(idx));
            check("out_re", out_re, 64'(16'(bre + 16'(idx))));
            check("out_im", out_im, 64'(16'(bim + 16'(idx))));
            check("out_last", out_last, (idx == 15) ? 64'd1 : 64'd0);
            check("in_ready_drain", in_ready, 0);
            tick();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        if (idx < nbeats) check("drain_budget", 64'(idx), 64'(nbeats));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b0;
        in_re        = '0;
        in_im        = '0;
        out_ready    = 1'b0;
        fft_endop    = 1'b0;
        fft_data_out = '0;
        repeat (2) tick();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_fft_start", fft_start, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_frames_done", frames_done, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_data_in_zero", 64'(|fft_data_in), 0);
        reset = 1'b1;
        tick();

        // Frame 1: re=k, im=-k; core answers after 20 cycles
        feed(16'h0000, 16'h0000, 16);
        check("slot0", fft_data_in[31:0], 64'h0000_0000);
        check("slot1", fft_data_in[63:32], 64'h0001_FFFF);
        check("slot15", fft_data_in[511:480], 64'h000F_FFF1);
        respond(20, 16'h0100, 16'h0200);
        drain(16'h0100, 16'h0200, 1'b0, 16);
        check("f1_valid_low", out_valid, 0);
        check("f1_frames_done", frames_done, 1);
        check("f1_in_ready", in_ready, 1);

        // Frame 2: sink backpressure
        feed(16'h0010, 16'h0000, 16);
        check("f2_slot3", fft_data_in[127:96], 64'h0013_FFFD);
        respond(5, 16'h0300, 16'h0400);
        drain(16'h0300, 16'h0400, 1'b1, 16);
        check("f2_frames_done", frames_done, 2);
        check("f2_in_ready", in_ready, 1);

        // Frame 3: core never answers -> timeout after 64 WAIT cycles
        feed(16'h0020, 16'h0000, 16);
        tick();
        repeat (63) tick();
        check("tmo_not_yet", timeout_err, 0);
        check("tmo_in_ready_low", in_ready, 0);
        tick();
        check("tmo_err_set", timeout_err, 1);
        check("tmo_back_to_fill", in_ready, 1);
        check("tmo_frames_same", frames_done, 2);
        check("tmo_no_valid", out_valid, 0);
        feed(16'h0030, 16'h0000, 16);
        respond(20, 16'h0500, 16'h0600);
        drain(16'h0500, 16'h0600, 1'b0, 16);
        check("tmo_next_frames", frames_done, 3);
        check("tmo_err_sticky", timeout_err, 1);

        // Frame 4: endop high from before start; capture only on the later rising edge
        load_core(16'hDE00, 16'hAD00);
        fft_endop = 1'b1;
        tick();
        feed(16'h0040, 16'h0000, 16);
        tick();
        repeat (5) tick();
        check("hi_no_capture", out_valid, 0);
        fft_endop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lo_no_capture", out_valid, 0);
        end
        load_core(16'h0700, 16'h0800);
        fft_endop = 1'b1;
        tick();
        check("rise_capture", out_valid, 1);
        fft_endop = 1'b0;
        drain(16'h0700, 16'h0800, 1'b0, 16);
        check("f4_frames_done", frames_done, 4);

        // Reset mid-FILL after 7 samples
        feed(16'h0050, 16'h0000, 7);
        reset = 1'b0;
        #1;
        check("rstf_in_ready", in_ready, 1);
        check("rstf_data_zero", 64'(|fft_data_in), 0);
        check("rstf_frames", frames_done, 0);
        check("rstf_tmo", timeout_err, 0);
        tick();
        reset = 1'b1;
        feed(16'h0060, 16'h0010, 16);
        check("fresh_slot0", fft_data_in[31:0], 64'h0060_0010);
        check("fresh_slot6", fft_data_in[223:192], 64'h0066_000A);
        respond(20, 16'h0900, 16'h0A00);

        // Reset mid-DRAIN at idx 9
        drain(16'h0900, 16'h0A00, 1'b0, 9);
        check("pre_rst_idx", out_idx, 9);
        reset = 1'b0;
        #1;
        check("rstd_valid", out_valid, 0);
        check("rstd_idx", out_idx, 0);
        check("rstd_last", out_last, 0);
        check("rstd_out_re", out_re, 0);
        check("rstd_in_ready", in_ready, 1);
        check("rstd_start", fft_start, 0);
        tick();
        reset = 1'b1;
        feed(16'h0070, 16'h0000, 16);
        check("post_slot0", fft_data_in[31:0], 64'h0070_0000);
        respond(8, 16'h0B00, 16'h0C00);
        drain(16'h0B00, 16'h0C00, 1'b0, 16);
        check("post_frames", frames_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_stream_adapter.md
Name: fft_stream_adapter

Overview:
- Streaming front/back end for the 16-point FFT core.
- Collects 16 complex samples from a valid/ready input stream and packs them into the core's wide parallel input bus.
- Issues the one-cycle start strobe, waits for the core's end-of-operation flag, captures the parallel result, and replays it as a valid/ready output stream.
- Sits between the sample source/sink and the FFT top, acting as the initiator to the core's start/endop handshake.

Parameters:
- DW, 16, bits per real or imaginary component.
- NPTS, 16, points per frame; the core supports only 16.
- TIMEOUT, 4096, maximum cycles to wait for endop before abandoning a frame.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  adapter can accept an input sample.
- in_re  in  DW  input real part, two's complement.
- in_im  in  DW  input imaginary part, two's complement.
- out_valid  out  1  output sample valid.
- out_ready  in  1  sink accepts the output sample.
- out_re  out  DW  output real part.
- out_im  out  DW  output imaginary part.
- out_idx  out  4  bin index of the current output sample.
- out_last  out  1  high when out_idx==NPTS-1 and out_valid=1.
- fft_data_in  out  2*DW*NPTS  packed frame driven to the core.
- fft_start  out  1  one-cycle start pulse to the core.
- fft_endop  in  1  core end-of-operation flag.
- fft_data_out  in  2*DW*NPTS  packed result from the core.
- timeout_err  out  1  sticky flag: a frame was abandoned on timeout.
- frames_done  out  16  count of fully drained frames; wraps at 2^16.

Behaviour:
- Packing, for both buses: sample k occupies bits [2*DW*k+2*DW-1 : 2*DW*k]; real in the upper DW bits, imaginary in the lower DW bits.
- Reset (reset=0, asynchronous): state=FILL; sample counter=0; fft_data_in=0; output buffer=0; fft_start=0; out_valid=0; out_idx=0; out_last=0; timeout_err=0; frames_done=0; timeout counter=0; endop history register=1.
  - A high endop at reset release is therefore not an edge.
  - Reset mid-frame discards all partial data; fft_start never glitches.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready, write {in_re,in_im} into slot[cnt] of fft_data_in and increment cnt.
  - The handshake at cnt=NPTS-1 moves the state to START and resets cnt to 0.
- START:
  - fft_start=1 for exactly one cycle; in_ready=0.
  - Next state WAIT; timeout counter cleared.
  - fft_data_in is held constant from the last FILL write until WAIT exits.
- WAIT:
  - in_ready=0; the timeout counter increments every cycle.
  - A rising edge of fft_endop (fft_endop=1 and history=0) latches fft_data_out into the output buffer on that edge and moves to DRAIN.
  - If the counter reaches TIMEOUT-1 with no edge, set timeout_err=1, discard the frame, and return to FILL.
  - If an endop edge and timeout occur in the same cycle, the edge wins.
- DRAIN:
  - out_valid=1; out_re/out_im = buffer slot[out_idx].
  - Outputs stay stable while out_valid&&!out_ready.
  - On handshake, out_idx increments.
  - A handshake at out_idx=NPTS-1 deasserts out_valid the next cycle, resets out_idx to 0, increments frames_done, and returns to FILL.
  - in_ready=0 throughout; input and output frames never overlap.
- Endop history register samples fft_endop every cycle in all states. Edges seen outside WAIT are ignored.
- fft_start is asserted only in START and never twice per frame.
- Latency:
  - 16th input handshake at cycle T gives fft_start=1 at T+1.
  - An endop rising edge sampled at cycle E gives out_valid=1 at E+1.
- timeout_err is cleared only by reset.

Test Plan:
- Reset, then feed samples k=0..15 with re=k, im=-k (in_valid held high) -> in_ready high for 16 cycles; fft_start pulses once 1 cycle after the 16th handshake; fft_data_in[31:0]=0x0000_0000, fft_data_in[63:32]=0x0001_FFFF.
- Behavioural core model raises endop 20 cycles after start with fft_data_out slot k = {k+0x100, k+0x200}, out_ready=1 -> out_valid starts 1 cycle after the edge; 16 consecutive beats with out_idx 0..15 and out_re=0x100+idx; out_last only on idx 15; frames_done=1.
- Sink backpressure with out_ready toggling 1,0,0,1... -> no beat dropped or duplicated; out_re/out_im stable while stalled; in_ready=0 until the last beat is accepted.
- TIMEOUT=64, core never raises endop -> timeout_err=1 exactly 64 cycles after entering WAIT; state returns to FILL (in_ready=1); frames_done unchanged; a following good frame completes normally with timeout_err still 1.
- fft_endop held high from before start, dropped 5 cycles into WAIT, raised again 10 cycles later -> capture occurs only on the second (rising) edge.
- Assert reset for 1 cycle mid-FILL after 7 samples and again mid-DRAIN at idx 9 -> all outputs return to reset values immediately; the next 16 samples form a fresh frame starting at slot 0.
